// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single DataMemory, with a bounded
// burst lock and a registered one-cycle read response per port.
module dm_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_t;

    lock_state_t      lock_owner, lock_owner_next;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
    logic             last_gnt, last_gnt_next;

    logic gnt0, gnt1, any_gnt, sel, sel_lock;
    lock_state_t sel_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_owner <= NONE;
            lock_cnt   <= '0;
            last_gnt   <= 1'b1;
        end else begin
            lock_owner <= lock_owner_next;
            lock_cnt   <= lock_cnt_next;
            last_gnt   <= last_gnt_next;
        end
    end

    // A lock only continues for the port already holding it (or starts from NONE),
    // so the owner never jumps directly between ports.
    always_comb begin
        lock_owner_next = lock_owner;
        lock_cnt_next   = lock_cnt;
        last_gnt_next   = last_gnt;
        if (!any_gnt) begin
            lock_owner_next = NONE;
            lock_cnt_next   = '0;
        end else begin
            last_gnt_next = sel;
            if (sel_lock && (lock_owner == NONE || lock_owner == sel_owner) &&
                lock_cnt < CNT_W'(LOCK_MAX - 1)) begin
                lock_owner_next = sel_owner;
                lock_cnt_next   = lock_cnt + 1'b1;
            end else begin
                lock_owner_next = NONE;
                lock_cnt_next   = '0;
            end
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (lock_owner == OWN0 && m0_req) begin
                gnt0 = 1'b1;
            end else if (lock_owner == OWN1 && m1_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
        any_gnt   = gnt0 | gnt1;
        sel       = gnt1;
        sel_lock  = gnt1 ? m1_lock : m0_lock;
        sel_owner = gnt1 ? OWN1 : OWN0;
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;

        mem_address = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (gnt0) begin
            mem_address = m0_addr;
            mem_wdata   = m0_wdata;
            mem_read    = ~m0_we;
            mem_write   = m0_we;
        end else if (gnt1) begin
            mem_address = m1_addr;
            mem_wdata   = m1_wdata;
            mem_read    = ~m1_we;
            mem_write   = m1_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0 & ~m0_we;
            m1_rvalid <= gnt1 & ~m1_we;
            if (gnt0 && !m0_we) m0_rdata <= mem_rdata;
            if (gnt1 && !m1_we) m1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a reference model predicts grants, memory
// drive and read responses; a negedge monitor compares them against the DUT.
module tb_dm_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    dm_arbiter #(.DATA_WIDTH(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for DataMemory: combinational read, write at posedge.
    logic [31:0] dmem [16];
    assign mem_rdata = dmem[mem_address[5:2]];
    always @(posedge clk) if (mem_write) dmem[mem_address[5:2]] <= mem_wdata;

    typedef struct packed {
        logic        g0, g1, rd, wr;
        logic [31:0] addr, wdata;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    exp_t  gnt_q[$];
    resp_t rd_q0[$], rd_q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    logic [31:0] ref_mem [16];
    int m_last, m_holder, m_streak, last_g;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelReset();
        m_last   = 1;
        m_holder = -1;
        m_streak = 0;
        rd_q0.delete();
        rd_q1.delete();
    endtask

    task automatic modelStep();
        exp_t        e;
        resp_t       r;
        int          g;
        logic        we, lk;
        logic [31:0] a, d;
        g = -1;
        if (m_holder == 0 && m0_req) g = 0;
        else if (m_holder == 1 && m1_req) g = 1;
        else if (m0_req && m1_req) g = (m_last == 0) ? 1 : 0;
        else if (m0_req) g = 0;
        else if (m1_req) g = 1;
        e = '0;
        last_g = g;
        if (g >= 0) begin
            we = (g == 0) ? m0_we : m1_we;
            lk = (g == 0) ? m0_lock : m1_lock;
            a  = (g == 0) ? m0_addr : m1_addr;
            d  = (g == 0) ? m0_wdata : m1_wdata;
            e.g0 = (g == 0); e.g1 = (g == 1);
            e.rd = !we; e.wr = we; e.addr = a; e.wdata = d;
            if (we) begin
                ref_mem[a[5:2]] = d;
            end else begin
                r.due = cyc + 1;
                r.data = ref_mem[a[5:2]];
                if (g == 0) rd_q0.push_back(r); else rd_q1.push_back(r);
            end
            m_last = g;
            if (lk && (m_holder == -1 || m_holder == g) && m_streak < LOCK_MAX - 1) begin
                m_holder = g;
                m_streak++;
            end else begin
                m_holder = -1;
                m_streak = 0;
            end
        end else begin
            m_holder = -1;
            m_streak = 0;
        end
        gnt_q.push_back(e);
    endtask

    // Drives one cycle of inputs (called at posedge+1), predicts, then advances.
    task automatic applyStimulus(input logic r0, input logic w0, input logic l0,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic l1,
                                 input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents grant or read data.
    always @(negedge clk) begin
        exp_t  e, act;
        logic  ev0, ev1;
        if (gnt_q.size() > 0) begin
            e = gnt_q.pop_front();
            act = {m0_gnt, m1_gnt, mem_read, mem_write, mem_address, mem_wdata};
            checkOutput("grant/mem", {32'h0, act[67:64], act[63:36]}, {32'h0, e[67:64], e[63:36]});
            checkOutput("mem_wdata", {32'h0, act[31:0]}, {32'h0, e[31:0]});
        end
        ev0 = (rd_q0.size() > 0) && (rd_q0[0].due == cyc);
        ev1 = (rd_q1.size() > 0) && (rd_q1[0].due == cyc);
        checkOutput("m0_rvalid", {63'h0, m0_rvalid}, {63'h0, ev0});
        checkOutput("m1_rvalid", {63'h0, m1_rvalid}, {63'h0, ev1});
        if (ev0) checkOutput("m0_rdata", {32'h0, m0_rdata}, {32'h0, rd_q0.pop_front().data});
        if (ev1) checkOutput("m1_rdata", {32'h0, m1_rdata}, {32'h0, rd_q1.pop_front().data});
    end

    initial begin
        logic        p0, p1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        modelReset();

        // Reset with both requests up and a write pending
        rst_n = 1'b0;
        m0_req = 1; m0_we = 1; m0_lock = 0; m0_addr = 32'h8; m0_wdata = 32'h1234_5678;
        m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 32'hC; m1_wdata = 32'h0;
        #2;
        checkOutput("reset m0_gnt", {63'h0, m0_gnt}, 64'h0);
        checkOutput("reset m1_gnt", {63'h0, m1_gnt}, 64'h0);
        checkOutput("reset mem_write", {63'h0, mem_write}, 64'h0);
        checkOutput("reset rvalid", {62'h0, m0_rvalid, m1_rvalid}, 64'h0);
        checkOutput("reset rdata", {m0_rdata, m1_rdata}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("[TB] reset released, first tie goes to port 0");
        applyStimulus(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'hC, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'hC, 0);

        // Port 0 write followed by port 1 read of the same word
        applyStimulus(1, 1, 0, 32'h4, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Continuous reads from both ports alternate
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'hC, 0);

        // Lock burst: make port 1 the last winner, then port 0 locks against port 1
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h14, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 32'h18, 0, 1, 0, 0, 32'h1C, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'h18, 0, 1, 0, 0, 32'h1C, 0);

        // Reset pulsed during a granted port 1 read, with a port 0 write pending
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 32'h20; m1_wdata = 0;
        modelStep();
        #6;
        rst_n = 1'b0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hBAD0BAD0;
        modelReset();
        #1;
        checkOutput("midreset gnt", {62'h0, m0_gnt, m1_gnt}, 64'h0);
        checkOutput("midreset mem_write", {63'h0, mem_write}, 64'h0);
        @(posedge clk); #1;
        checkOutput("midreset m1_rvalid", {63'h0, m1_rvalid}, 64'h0);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 32'h24, 0, 1, 0, 0, 32'h28, 0);

        // Idle cycle, then confirm memory was untouched by idle and reset cycles
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0);

        // Randomized traffic honoring the hold-until-grant handshake
        p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; w0 = 1'($urandom_range(0, 1));
                a0 = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1; w1 = 1'($urandom_range(0, 1));
                a1 = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; d1 = $urandom;
            end
            applyStimulus(p0, w0, 1'($urandom_range(0, 1)), a0, d0,
                          p1, w1, 1'($urandom_range(0, 1)), a1, d1);
            if (last_g == 0) p0 = 0;
            if (last_g == 1) p1 = 0;
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("leftover expectations", 64'(gnt_q.size() + rd_q0.size() + rd_q1.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
